// File: rtl/gnt_packet_mux.sv
// gnt_packet_mux: locks onto the client granted by the upstream round-robin arbiter
// and forwards that client's packet through a single registered output stage.
module gnt_packet_mux #(
    parameter int CLIENTS = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    localparam int IDW    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CLIENTS-1:0]    gnt,
    input  logic [CLIENTS-1:0]    s_valid,
    input  logic [CLIENTS*DW-1:0] s_data,
    input  logic [CLIENTS-1:0]    s_last,
    output logic [CLIENTS-1:0]    s_ready,
    output logic                  m_valid,
    output logic [DW-1:0]         m_data,
    output logic                  m_last,
    output logic [IDW-1:0]        m_id,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_gnt,
    output logic                  timeout_pulse,
    output logic [15:0]           drop_cnt
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        BUSY = 2'b10
    } state_t;

    state_t         state;
    logic [IDW-1:0] owner;
    logic [TW-1:0]  idle_cnt;

    logic           gnt_any;
    logic           gnt_multi;
    logic [IDW-1:0] gnt_idx;
    logic           out_free;
    logic           owner_valid;
    logic           owner_last;
    logic [DW-1:0]  owner_data;
    logic           accept;
    logic           timed_out;

    assign gnt_any   = |gnt;
    assign gnt_multi = |(gnt & (gnt - CLIENTS'(1)));

    // Lowest set bit wins when the arbiter misbehaves and grants several clients.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        gnt_idx = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (gnt[i]) gnt_idx = IDW'(i);
        end
    end

    assign busy        = (state == BUSY);
    assign out_free    = !m_valid || m_ready;
    assign owner_valid = s_valid[owner];
    assign owner_last  = s_last[owner];
    assign owner_data  = s_data[owner*DW +: DW];
    assign accept      = busy && owner_valid && out_free;
    assign timed_out   = (TIMEOUT > 0) && busy && !accept && (idle_cnt == TW'(TIMEOUT));

    always_comb begin
        s_ready = '0;
        if (busy) s_ready[owner] = out_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= '0;
            idle_cnt      <= '0;
            err_gnt       <= 1'b0;
            timeout_pulse <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state    <= BUSY;
                        owner    <= gnt_idx;
                        idle_cnt <= '0;
                        if (gnt_multi) err_gnt <= 1'b1;
                    end
                end
                BUSY: begin
                    if (gnt_any && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
                    // A stalled-but-valid owner is making progress, so it never ages.
                    if (accept) begin
                        idle_cnt <= '0;
                        if (owner_last) state <= IDLE;
                    end else if (timed_out) begin
                        state         <= IDLE;
                        timeout_pulse <= 1'b1;
                    end else if (!owner_valid && (TIMEOUT > 0)) begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                // NOTE: the one-hot encoding leaves unused codes; any of them recovers to IDLE.
                default: state <= IDLE;
            endcase
        end
    end

    // Output register holds its beat until the sink takes it; a held beat drains after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= owner_data;
            m_last  <= owner_last;
            m_id    <= owner;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gnt_packet_mux.sv
// Self-checking bench for gnt_packet_mux: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_gnt_packet_mux;

    localparam int TIMEOUT = 15;

    logic          clk;
    logic          rst;
    logic [15:0]   gnt;
    logic [15:0]   s_valid;
    logic [511:0]  s_data;
    logic [15:0]   s_last;
    logic [15:0]   s_ready;
    logic          m_valid;
    logic [31:0]   m_data;
    logic          m_last;
    logic [3:0]    m_id;
    logic          m_ready;
    logic          busy;
    logic          err_gnt;
    logic          timeout_pulse;
    logic [15:0]   drop_cnt;

    gnt_packet_mux #(.CLIENTS(16), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_id(m_id), .m_ready(m_ready), .busy(busy),
        .err_gnt(err_gnt), .timeout_pulse(timeout_pulse), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    // Reference model: who owns the channel, how long it has idled, and what sits in the output slot.
    typedef struct {
        int          id;
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t out_q[$];
    bit    md_busy;
    int    md_owner;
    int    md_idle;
    int    md_drop;
    bit    md_err;
    bit    md_tp;
    int    acc_id;

    bit          src_v[16];
    logic [31:0] src_d[16];
    bit          src_l[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] g);
        for (int i = 0; i < 16; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        out_q.delete();
        md_busy  = 1'b0;
        md_owner = 0;
        md_idle  = 0;
        md_drop  = 0;
        md_err   = 1'b0;
        md_tp    = 1'b0;
        acc_id   = -1;
    endtask

    function automatic logic [15:0] exp_ready();
        if (md_busy && (out_q.size() == 0 || m_ready)) return 16'(1) << md_owner;
        return 16'h0;
    endfunction

    task automatic model_edge();
        bit    free;
        bit    acc;
        beat_t b;
        free   = (out_q.size() == 0) || m_ready;
        acc    = md_busy && s_valid[md_owner] && free;
        acc_id = acc ? md_owner : -1;
        if (m_ready && out_q.size() != 0) void'(out_q.pop_front());
        if (acc) begin
            b.id   = md_owner;
            b.data = s_data[md_owner*32 +: 32];
            b.last = s_last[md_owner];
            out_q.push_back(b);
        end
        md_tp = 1'b0;
        if (!md_busy) begin
            if (gnt != 0) begin
                md_busy  = 1'b1;
                md_owner = lowest(gnt);
                md_idle  = 0;
                if ($countones(gnt) > 1) md_err = 1'b1;
            end
        end else begin
            if (gnt != 0 && md_drop < 65535) md_drop++;
            if (acc) begin
                md_idle = 0;
                if (b.last) md_busy = 1'b0;
            end else if (TIMEOUT > 0 && md_idle == TIMEOUT) begin
                md_busy = 1'b0;
                md_tp   = 1'b1;
            end else if (!s_valid[md_owner]) begin
                md_idle++;
            end
        end
    endtask

    task automatic check_outputs();
        check("m_valid", m_valid, out_q.size() != 0);
        if (out_q.size() != 0) begin
            check("m_data", m_data, out_q[0].data);
            check("m_last", m_last, out_q[0].last);
            check("m_id", m_id, out_q[0].id);
        end
        check("busy", busy, md_busy);
        check("err_gnt", err_gnt, md_err);
        check("timeout_pulse", timeout_pulse, md_tp);
        check("drop_cnt", drop_cnt, md_drop);
    endtask

    // Starts and ends on a falling edge; inputs must already be driven.
    task automatic cycle();
        #1;
        if (chk_en) check("s_ready", s_ready, exp_ready());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (chk_en) check_outputs();
    endtask

    task automatic beat(input int c, input logic [31:0] d, input bit l);
        s_valid            = 16'(1) << c;
        s_data             = '0;
        s_data[c*32 +: 32] = d;
        s_last             = 16'(l) << c;
    endtask

    task automatic idle();
        s_valid = '0;
        s_last  = '0;
    endtask

    int p;
    int r;

    initial begin
        rst = 1'b1; gnt = '0; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
        model_reset();
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_id", m_id, 4'h0);
        check("rst_s_ready", s_ready, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_gnt, 1'b0);
        check("rst_tp", timeout_pulse, 1'b0);
        check("rst_drop", drop_cnt, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic three-beat packet from client 2
        gnt = 16'h0004; cycle(); gnt = '0;
        check("basic_busy", busy, 1'b1);
        beat(2, 32'hA0, 1'b0); cycle();
        check("basic_d0", m_data, 32'hA0);
        check("basic_id", m_id, 4'd2);
        beat(2, 32'hA1, 1'b0); cycle();
        check("basic_d1", m_data, 32'hA1);
        check("basic_l1", m_last, 1'b0);
        beat(2, 32'hA2, 1'b1); cycle();
        check("basic_d2", m_data, 32'hA2);
        check("basic_l2", m_last, 1'b1);
        check("basic_release", busy, 1'b0);
        idle(); cycle();

        // Backpressure on the second beat
        gnt = 16'h0004; cycle(); gnt = '0;
        beat(2, 32'hA0, 1'b0); cycle();
        beat(2, 32'hA1, 1'b0); cycle();
        beat(2, 32'hA2, 1'b1); m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold", m_data, 32'hA1);
            check("bp_sready", s_ready[2], 1'b0);
            cycle();
        end
        m_ready = 1'b1; cycle();
        check("bp_d2", m_data, 32'hA2);
        check("bp_l2", m_last, 1'b1);
        idle(); cycle();

        // Grants while BUSY are dropped and counted
        gnt = 16'h0004; cycle();
        for (int k = 1; k <= 5; k++) begin
            beat(2, 32'hB0 + k, k == 5);
            gnt = (k == 2 || k == 4) ? 16'h0100 : 16'h0000;
            cycle();
        end
        gnt = '0; idle();
        check("drop_two", drop_cnt, 16'd2);
        check("drop_owner", m_id, 4'd2);
        cycle();

        // Multi-grant error, then drop counter saturation under a stalled owner
        gnt = 16'h0030; cycle(); gnt = '0;
        check("multi_err", err_gnt, 1'b1);
        beat(4, 32'hC0, 1'b0); m_ready = 1'b0; cycle();
        check("multi_id", m_id, 4'd4);
        beat(4, 32'hC1, 1'b1); gnt = 16'h8000;
        chk_en = 1'b0;
        repeat (65540) cycle();
        chk_en = 1'b1;
        cycle();
        check("sat_drop", drop_cnt, 16'hFFFF);
        check("sat_busy", busy, 1'b1);
        gnt = '0; m_ready = 1'b1; cycle();
        check("multi_last_id", m_id, 4'd4);
        check("multi_last", m_last, 1'b1);
        idle(); cycle();
        check("multi_err_sticky", err_gnt, 1'b1);

        // Idle timeout with a silent owner, then a normal grant
        gnt = 16'h0001; cycle(); gnt = '0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("to_pulse", timeout_pulse, k == 16);
            check("to_busy", busy, k < 16);
        end
        cycle();
        check("to_pulse_once", timeout_pulse, 1'b0);
        gnt = 16'h0002; cycle(); gnt = '0;
        beat(1, 32'hD0, 1'b1); cycle();
        check("to_next_id", m_id, 4'd1);
        check("to_next_data", m_data, 32'hD0);
        idle(); cycle();

        // Asynchronous reset with a beat held in the output register
        gnt = 16'h0008; cycle(); gnt = '0;
        beat(3, 32'hE0, 1'b0); cycle();
        m_ready = 1'b0; beat(3, 32'hE1, 1'b0); cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_s_ready", s_ready, 16'h0);
        check("arst_drop", drop_cnt, 16'h0);
        check("arst_err", err_gnt, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b1; idle();
        gnt = 16'h0008; cycle(); gnt = '0;
        beat(3, 32'hF0, 1'b1); cycle();
        check("arst_fresh_data", m_data, 32'hF0);
        check("arst_fresh_id", m_id, 4'd3);
        idle(); cycle();

        // Random traffic: busy phase, then sparse valids to provoke timeouts
        for (int n = 0; n < 1600; n++) begin
            p = (n < 1000) ? 35 : 4;
            for (int c = 0; c < 16; c++) begin
                if (!src_v[c] && $urandom_range(99) < p) begin
                    src_v[c] = 1'b1;
                    src_d[c] = $urandom;
                    src_l[c] = ($urandom_range(3) == 0);
                end
                s_valid[c]         = src_v[c];
                s_data[c*32 +: 32] = src_d[c];
                s_last[c]          = src_l[c];
            end
            r = $urandom_range(99);
            if (r < 8)       gnt = 16'(1) << $urandom_range(15);
            else if (r < 10) gnt = 16'($urandom_range(65535, 1));
            else             gnt = '0;
            m_ready = ($urandom_range(3) != 0);
            cycle();
            if (acc_id >= 0) src_v[acc_id] = 1'b0;
        end
        gnt = '0; idle(); m_ready = 1'b1;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
